exp_sum_block: RTL and testbench
================================

EXP_SUM_BLOCK -- requirements
Module: exp_sum_block

Interface
REQ-001 SHALL have parameter data_size, default 32, width of one exp value in unsigned fixed point.
REQ-002 SHALL have parameter number_of_data, default 10, number of values per softmax vector (2..255).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clock_i, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port exp_data_i, input, data_size, exp value from the exp stage.
REQ-007 SHALL have port exp_data_valid_i, input, 1, exp_data_i valid this cycle; there is no ready back-pressure.
REQ-008 SHALL have port div_ready_i, input, 1, divide stage accepts num_data_o this cycle.
REQ-009 SHALL have port sum_o, output, data_size+4, accumulated sum of one vector.
REQ-010 SHALL have port sum_valid_o, output, 1, one-cycle pulse marking a new sum_o.
REQ-011 SHALL have port num_data_o, output, data_size, buffered exp value (numerator) to the divide stage.
REQ-012 SHALL have port num_data_valid_o, output, 1, num_data_o valid.
REQ-013 SHALL have port sum_done_o, output, 1, one-cycle pulse after the last numerator is accepted.
REQ-014 SHALL have port overrun_o, output, 1, sticky flag: an input was dropped.

Function
REQ-015 SHALL implement FSM states COLLECT, SUM, STREAM and DONE, and SHALL enter COLLECT on reset.
REQ-016 In COLLECT, each cycle with exp_data_valid_i SHALL write buffer[wr_cnt]<=exp_data_i, set acc<=acc+zero-extended exp_data_i and increment wr_cnt.
REQ-017 Gaps in exp_data_valid_i SHALL be tolerated, with no change to acc or wr_cnt on invalid cycles.
REQ-018 The edge that accepts input number_of_data SHALL move COLLECT to SUM, so sum_o becomes visible one cycle after the last input is captured.
REQ-019 In SUM, sum_o SHALL equal the final acc and sum_valid_o SHALL be 1 for exactly that cycle.
REQ-020 SUM SHALL always pass to STREAM on the next cycle, with rd_idx=0.
REQ-021 sum_o SHALL hold its value until the next SUM state.
REQ-022 In STREAM, num_data_o SHALL equal buffer[rd_idx] and num_data_valid_o SHALL be 1.
REQ-023 In STREAM, rd_idx SHALL advance only on a cycle with div_ready_i=1.
REQ-024 num_data_o SHALL stay stable while num_data_valid_o=1 and div_ready_i=0.
REQ-025 Acceptance of rd_idx=number_of_data-1 SHALL move STREAM to DONE.
REQ-026 In DONE, sum_done_o SHALL be 1 for one cycle, acc and wr_cnt SHALL clear to 0, and the next state SHALL be COLLECT.
REQ-027 exp_data_valid_i in SUM, STREAM or DONE SHALL drop the data, leave buffer and acc unchanged, and set overrun_o.
REQ-028 overrun_o SHALL clear only on reset.
REQ-029 The accumulator SHALL be data_size+4 bits wide, so it cannot wrap for number_of_data<=16.
REQ-030 Values SHALL be added unsigned with no rounding or saturation.
REQ-031 num_data_valid_o SHALL be 0 outside STREAM.
REQ-032 sum_valid_o SHALL be 0 outside SUM.
REQ-033 sum_done_o SHALL be 0 outside DONE.

Reset
REQ-034 Reset SHALL force state=COLLECT and wr_cnt, rd_idx and acc to 0.
REQ-035 Reset SHALL force sum_o, sum_valid_o, num_data_o, num_data_valid_o, sum_done_o and overrun_o to 0.
REQ-036 Buffer contents SHALL need no reset.
REQ-037 Reset asserted in any state, including mid-STREAM, SHALL abandon the vector, with no sum_done_o pulse.
REQ-038 The first input accepted after reset deasserts SHALL be element 0.

Structure
REQ-039 A shared softmax package SHALL hold the FSM state encodings and the default number_of_data.
REQ-040 The shared softmax package SHALL hold the sum guard-bit constant (4).
REQ-041 The buffer SHALL be a natural sub-module, sum_buffer: number_of_data x data_size, one write port, one combinational read port.
REQ-042 Counters SHALL be 8 bits wide.

Verification
REQ-043 Ten back-to-back inputs of 0x00010000 -> sum_o=0x0000A0000 with sum_valid_o one cycle after the 10th input, then ten num_data_o=0x00010000 beats with div_ready_i=1, then a sum_done_o pulse.
REQ-044 Inputs 1..10 with two idle cycles between each -> sum_o=55, and num_data_o streams 1..10 in order.
REQ-045 Ten inputs of 0xFFFFFFFF -> sum_o=0x9FFFFFFF6 with no wrap.
REQ-046 div_ready_i toggling 1,0,0,1,... during STREAM -> each num_data_o is held while div_ready_i=0, with no loss or duplication, and sum_done_o occurs only after the 10th acceptance.
REQ-047 exp_data_valid_i asserted during STREAM -> overrun_o=1, and the streamed values and sum_o are unchanged.
REQ-048 Reset on the 4th STREAM beat -> all outputs are 0 the next cycle, and a following 10-value vector sums correctly.

Source files
------------

// File: rtl/exp_sum_block_pkg.sv
// exp_sum_block_pkg: shared softmax FSM encodings, default vector length, sum guard bits and counter width
package exp_sum_block_pkg;
    typedef enum logic [1:0] {COLLECT, SUM, STREAM, DONE} state_t;
    localparam int NUMBER_OF_DATA_DEFAULT = 10;
    localparam int SUM_GUARD_BITS = 4;
    localparam int CNT_W = 8;
endpackage

// File: rtl/exp_sum_block_sum_buffer.sv
// sum_buffer: one-vector numerator store, one synchronous write port, one combinational read port
module sum_buffer #(
    parameter int data_size = 32,
    parameter int depth = 10,
    parameter int addr_size = 4
) (
    input  logic                 clock_i,
    input  logic                 write_en,
    input  logic [addr_size-1:0] write_addr,
    input  logic [data_size-1:0] write_data,
    input  logic [addr_size-1:0] read_addr,
    output logic [data_size-1:0] read_data
);
    logic [data_size-1:0] mem [depth];
    always_ff @(posedge clock_i) begin
        if (write_en) mem[write_addr] <= write_data;
    end
    assign read_data = mem[read_addr];
endmodule

// File: rtl/exp_sum_block.sv
// exp_sum_block: collects one softmax vector of exp values, publishes its sum, then streams the numerators
module exp_sum_block
    import exp_sum_block_pkg::*;
#(
    parameter int data_size = 32,
    parameter int number_of_data = NUMBER_OF_DATA_DEFAULT
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic [data_size-1:0]                exp_data_i,
    input  logic                                exp_data_valid_i,
    input  logic                                div_ready_i,
    output logic [data_size+SUM_GUARD_BITS-1:0] sum_o,
    output logic                                sum_valid_o,
    output logic [data_size-1:0]                num_data_o,
    output logic                                num_data_valid_o,
    output logic                                sum_done_o,
    output logic                                overrun_o
);
    localparam int acc_size = data_size + SUM_GUARD_BITS;
    localparam int addr_size = $clog2(number_of_data);
    localparam logic [CNT_W-1:0] last_idx = CNT_W'(number_of_data - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] wr_cnt, rd_idx;
    logic [acc_size-1:0] acc, acc_n, sum_q;
    logic [data_size-1:0] rd_data;
    logic overrun_q, accept_in, last_in, accept_out, last_out;
    sum_buffer #(
        .data_size(data_size),
        .depth(number_of_data),
        .addr_size(addr_size)
    ) u_buffer (
        .clock_i(clock_i),
        .write_en(accept_in),
        .write_addr(wr_cnt[addr_size-1:0]),
        .write_data(exp_data_i),
        .read_addr(rd_idx[addr_size-1:0]),
        .read_data(rd_data)
    );
    assign acc_n = acc + acc_size'(exp_data_i);
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state     <= COLLECT;
            wr_cnt    <= '0;
            rd_idx    <= '0;
            acc       <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept_in) begin
                acc    <= acc_n;
                wr_cnt <= wr_cnt + 8'd1;
            end
            if (last_in) sum_q <= acc_n;
            if (state == SUM) rd_idx <= '0;
            if (accept_out) rd_idx <= rd_idx + 8'd1;
            if (state == DONE) begin
                acc    <= '0;
                wr_cnt <= '0;
            end
            if (exp_data_valid_i && state != COLLECT) overrun_q <= 1'b1;
        end
    end
    always_comb begin
        accept_in        = state == COLLECT && exp_data_valid_i;
        last_in          = accept_in && wr_cnt == last_idx;
        accept_out       = state == STREAM && div_ready_i;
        last_out         = accept_out && rd_idx == last_idx;
        state_n          = state == COLLECT ? (last_in ? SUM : COLLECT) :
                           state == SUM     ? STREAM :
                           state == STREAM  ? (last_out ? DONE : STREAM) : COLLECT;
        sum_o            = sum_q;
        sum_valid_o      = state == SUM;
        num_data_valid_o = state == STREAM;
        num_data_o       = state == STREAM ? rd_data : '0;
        sum_done_o       = state == DONE;
        overrun_o        = overrun_q;
    end
endmodule

// File: tb/tb_exp_sum_block.sv
// tb_exp_sum_block: directed vectors against a queue-based transaction model plus hand-computed pins
module tb_exp_sum_block;
    localparam int DW = 32;
    localparam int N = 10;
    localparam int AW = DW + 4;
    localparam int M_COL = 0, M_SUM = 1, M_STR = 2, M_DONE = 3;

    logic clk = 1'b0, rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic din_v = 1'b0, rdy = 1'b0;
    logic [AW-1:0] sum;
    logic sum_v, num_v, done, ovr;
    logic [DW-1:0] num;

    exp_sum_block #(.data_size(DW), .number_of_data(N)) dut (
        .clock_i(clk),
        .reset_i(rst),
        .exp_data_i(din),
        .exp_data_valid_i(din_v),
        .div_ready_i(rdy),
        .sum_o(sum),
        .sum_valid_o(sum_v),
        .num_data_o(num),
        .num_data_valid_o(num_v),
        .sum_done_o(done),
        .overrun_o(ovr)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transaction model: the collected vector, its sum, and which phase the block is in
    logic [DW-1:0] col[$];
    int mode = M_COL, ridx = 0;
    logic [AW-1:0] m_sum = '0;
    bit m_ovr = 1'b0, armed = 1'b0;

    function automatic logic [AW-1:0] qsum(input logic [DW-1:0] q[$]);
        logic [AW-1:0] s = '0;
        foreach (q[i]) s += AW'(q[i]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mode <= M_COL;
            ridx <= 0;
            m_sum <= '0;
            m_ovr <= 1'b0;
            armed <= 1'b1;
            col.delete();
        end else begin
            if (din_v && mode != M_COL) m_ovr <= 1'b1;
            case (mode)
                M_COL: if (din_v) begin
                    if (col.size() == N - 1) begin
                        m_sum <= qsum(col) + AW'(din);
                        mode <= M_SUM;
                    end
                    col.push_back(din);
                end
                M_SUM: begin
                    mode <= M_STR;
                    ridx <= 0;
                end
                M_STR: if (rdy) begin
                    ridx <= ridx + 1;
                    if (ridx == N - 1) mode <= M_DONE;
                end
                default: begin
                    col.delete();
                    mode <= M_COL;
                end
            endcase
        end
    end

    logic [DW-1:0] got[$];
    logic [AW-1:0] last_sum = '0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (armed) begin
            chk("sum_o", 64'(sum), 64'(m_sum));
            chk("sum_valid_o", 64'(sum_v), 64'(mode == M_SUM));
            chk("num_data_valid_o", 64'(num_v), 64'(mode == M_STR));
            chk("sum_done_o", 64'(done), 64'(mode == M_DONE));
            chk("overrun_o", 64'(ovr), 64'(m_ovr));
            if (mode == M_STR) chk("num_data_o", 64'(num), 64'(col[ridx]));
            if (sum_v) last_sum <= sum;
            if (num_v && rdy) got.push_back(num);
            if (done) begin
                chk("done_after_all", 64'(got.size()), 64'(N));
                done_cnt <= done_cnt + 1;
            end
        end
    end

    logic [DW-1:0] vec[N];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int gap);
        for (int i = 0; i < N; i++) begin
            din_v = 1'b1;
            din = vec[i];
            step();
            din_v = 1'b0;
            if (i < N - 1) repeat (gap) step();
        end
    endtask

    task automatic wait_done(input bit toggle, input bit inject);
        int start = done_cnt;
        for (int k = 0; k < 300; k++) begin
            rdy = toggle ? (k % 3 == 0) : 1'b1;
            din_v = inject && k == 4;
            din = 32'hDEAD_BEEF;
            step();
            if (done_cnt != start) break;
        end
        din_v = 1'b0;
        rdy = 1'b0;
        chk("done_pulse_seen", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, 64'(got.size()), 64'(N));
        for (int i = 0; i < N && i < got.size(); i++) chk({tag, "_beat"}, 64'(got[i]), 64'(vec[i]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_sum"}, 64'(sum), 64'd0);
        chk({tag, "_sum_valid"}, 64'(sum_v), 64'd0);
        chk({tag, "_num"}, 64'(num), 64'd0);
        chk({tag, "_num_valid"}, 64'(num_v), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_overrun"}, 64'(ovr), 64'd0);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        foreach (vec[i]) vec[i] = 32'h0001_0000;
        got.delete();
        send_vec(0);
        chk("v1_sum_valid_now", 64'(sum_v), 64'd1);
        chk("v1_sum", 64'(sum), 64'h0_000A_0000);
        wait_done(1'b0, 1'b0);
        chk_stream("v1");

        foreach (vec[i]) vec[i] = DW'(i + 1);
        got.delete();
        send_vec(2);
        chk("v2_sum_valid_now", 64'(sum_v), 64'd1);
        wait_done(1'b0, 1'b0);
        chk("v2_sum", 64'(last_sum), 64'd55);
        chk_stream("v2");

        foreach (vec[i]) vec[i] = 32'hFFFF_FFFF;
        got.delete();
        send_vec(0);
        wait_done(1'b0, 1'b0);
        chk("v3_sum_nowrap", 64'(last_sum), 64'h9_FFFF_FFF6);
        chk_stream("v3");

        foreach (vec[i]) vec[i] = DW'((i + 1) * 'h111);
        got.delete();
        send_vec(1);
        wait_done(1'b1, 1'b0);
        chk("v4_sum", 64'(last_sum), 64'd15015);
        chk_stream("v4");
        chk("v4_no_overrun", 64'(ovr), 64'd0);

        foreach (vec[i]) vec[i] = DW'(100 + i);
        got.delete();
        send_vec(0);
        wait_done(1'b0, 1'b1);
        chk("v5_overrun", 64'(ovr), 64'd1);
        chk("v5_sum", 64'(last_sum), 64'd1045);
        chk_stream("v5");

        foreach (vec[i]) vec[i] = DW'(i + 1);
        got.delete();
        send_vec(0);
        for (int k = 0; k < 50 && got.size() < 3; k++) begin
            rdy = 1'b1;
            step();
        end
        chk("v6_three_beats", 64'(got.size()), 64'd3);
        chk("v6_overrun_sticky", 64'(ovr), 64'd1);
        d0 = done_cnt;
        rdy = 1'b0;
        rst = 1'b1;
        step();
        chk_zero("v6_reset");
        rst = 1'b0;
        step();
        chk("v6_no_done", 64'(done_cnt), 64'(d0));

        foreach (vec[i]) vec[i] = DW'(5 + i);
        got.delete();
        send_vec(0);
        chk("v7_sum", 64'(sum), 64'd95);
        wait_done(1'b0, 1'b0);
        chk_stream("v7");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
